// File: rtl/decrypt_copy_engine.sv
// decrypt_copy_engine
//   Copies count words from the encrypted region (reads at 0x400 + 4*i) to
//   the decrypted region (writes at 0x404 + 4*i), XORing each word with a
//   key latched at start. Each word takes three cycles: read request, read
//   wait (data captured), write. A one-cycle done pulse follows the last write.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   start             begin a job (accepted only in IDLE)
//   word_count, key   job operands, sampled with an accepted start
//   mem_rdata         read data, valid one cycle after the read address
//   mem_address       byte address to the memory-map decoder
//   mem_we, mem_wdata write strobe and data
//   busy              high whenever not IDLE
//   done              one-cycle completion pulse
//   words_done        words written in the current or last job
module decrypt_copy_engine #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] word_count,
    input  logic [N-1:0] key,
    input  logic [N-1:0] mem_rdata,
    output logic [N-1:0] mem_address,
    output logic         mem_we,
    output logic [N-1:0] mem_wdata,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] words_done
);

    typedef enum logic [2:0] {
        IDLE,
        READ_REQ,
        READ_WAIT,
        WRITE,
        DONE
    } state_t;

    // Word capacity of the encrypted region; clamping here keeps every
    // address inside [0x400, 0x14000], so N-bit arithmetic can never wrap.
    localparam logic [N-1:0] MAX_WORDS = N'(32'h4F00);
    localparam logic [N-1:0] RD_BASE   = N'(32'h400);
    localparam logic [N-1:0] WR_BASE   = N'(32'h404);

    state_t       state_q, state_d;
    logic [N-1:0] i_q, i_d;
    logic [N-1:0] count_q, count_d;
    logic [N-1:0] key_q, key_d;
    logic [N-1:0] word_q, word_d;
    logic [N-1:0] words_done_q, words_done_d;

    logic [N-1:0] count_in;
    logic [N-1:0] offset;

    assign count_in = (word_count > MAX_WORDS) ? MAX_WORDS : word_count;
    assign offset   = {i_q[N-3:0], 2'b00};

    always_comb begin
        state_d      = state_q;
        i_d          = i_q;
        count_d      = count_q;
        key_d        = key_q;
        word_d       = word_q;
        words_done_d = words_done_q;
        mem_address  = '0;
        mem_we       = 1'b0;
        mem_wdata    = '0;
        done         = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    key_d        = key;
                    count_d      = count_in;
                    i_d          = '0;
                    words_done_d = '0;
                    state_d      = (count_in == '0) ? DONE : READ_REQ;
                end
            end
            READ_REQ: begin
                mem_address = RD_BASE + offset;
                state_d     = READ_WAIT;
            end
            READ_WAIT: begin
                // Address is held so the read data for it arrives this cycle.
                mem_address = RD_BASE + offset;
                word_d      = mem_rdata;
                state_d     = WRITE;
            end
            WRITE: begin
                mem_address  = WR_BASE + offset;
                mem_we       = 1'b1;
                mem_wdata    = word_q ^ key_q;
                i_d          = i_q + 1'b1;
                words_done_d = words_done_q + 1'b1;
                state_d      = (i_d == count_q) ? DONE : READ_REQ;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy       = (state_q != IDLE);
    assign words_done = words_done_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            i_q          <= '0;
            count_q      <= '0;
            key_q        <= '0;
            word_q       <= '0;
            words_done_q <= '0;
        end else begin
            state_q      <= state_d;
            i_q          <= i_d;
            count_q      <= count_d;
            key_q        <= key_d;
            word_q       <= word_d;
            words_done_q <= words_done_d;
        end
    end

endmodule

// File: tb/tb_decrypt_copy_engine.sv
// Directed testbench for decrypt_copy_engine. A small memory model returns
// registered read data; a per-cycle monitor records reads, writes, done and
// busy while a job runs, and each test task compares against hand values.
module tb_decrypt_copy_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] word_count = '0;
    logic [31:0] key = '0;
    logic [31:0] mem_rdata = '0;
    logic [31:0] mem_address;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic [31:0] words_done;

    int pass_cnt = 0;
    int total_cnt = 0;

    decrypt_copy_engine #(.N(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .word_count (word_count),
        .key        (key),
        .mem_rdata  (mem_rdata),
        .mem_address(mem_address),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .done       (done),
        .words_done (words_done)
    );

    always #5 clk = ~clk;

    // Source memory: first 8 words from a table, the rest return their index.
    logic [31:0] src_mem [0:7];
    function automatic logic [31:0] src_word(input logic [31:0] a);
        logic [31:0] idx;
        idx = (a - 32'h400) >> 2;
        if (idx < 8) return src_mem[idx[2:0]];
        return idx;
    endfunction

    always @(posedge clk) mem_rdata <= src_word(mem_address);

    // Monitor results of the last job
    logic [31:0] wr_a[$];
    logic [31:0] wr_d[$];
    int          wr_c[$];
    logic [31:0] rd_a[$];
    int          rd_c[$];
    int          wr_n, rd_n, done_cnt, done_cyc, busy_cnt;
    logic [31:0] wd_at_done, last_wa, max_ra;
    logic        busy_after;

    // Runs one job; optionally re-pulses start with other operands at cycle rs_cyc.
    task automatic run_job(input logic [31:0] wc, input logic [31:0] k, input int maxc,
                           input int rs_cyc, input logic [31:0] rs_wc, input logic [31:0] rs_k);
        int cyc;
        wr_a.delete(); wr_d.delete(); wr_c.delete(); rd_a.delete(); rd_c.delete();
        wr_n = 0; rd_n = 0; done_cnt = 0; done_cyc = -1; busy_cnt = 0;
        wd_at_done = 'x; last_wa = 0; max_ra = 0; busy_after = 1'b1;
        @(negedge clk);
        start = 1'b1; word_count = wc; key = k;
        cyc = 0;
        while (cyc < maxc) begin
            @(negedge clk);
            cyc++;
            start = (cyc == rs_cyc);
            if (cyc == rs_cyc) begin word_count = rs_wc; key = rs_k; end
            if (busy) busy_cnt++;
            if (mem_we) begin
                wr_n++; last_wa = mem_address;
                if (wr_a.size() < 16) begin
                    wr_a.push_back(mem_address); wr_d.push_back(mem_wdata); wr_c.push_back(cyc);
                end
            end else if (busy && mem_address != 0) begin
                rd_n++;
                if (mem_address > max_ra) max_ra = mem_address;
                if (rd_a.size() < 16) begin rd_a.push_back(mem_address); rd_c.push_back(cyc); end
            end
            if (done) begin done_cnt++; done_cyc = cyc; wd_at_done = words_done; end
            if (done_cnt > 0 && cyc == done_cyc + 1) begin busy_after = busy; break; end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total_cnt++;
        if ({mem_address, mem_we, mem_wdata, busy, done, words_done} !== '0)
            $display("FAIL reset_outputs: got addr=%h we=%b wd=%h busy=%b done=%b wdn=%h want all 0",
                     mem_address, mem_we, mem_wdata, busy, done, words_done);
        else pass_cnt++;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL reset_idle_busy: got %b want 0", busy); else pass_cnt++;
    endtask

    task automatic test_single();
        src_mem[0] = 32'h12345678;
        run_job(32'd1, 32'hA5A5A5A5, 20, -1, 0, 0);
        total_cnt++;
        if (rd_a.size() < 1 || rd_a[0] !== 32'h400 || rd_c[0] != 1)
            $display("FAIL single_read: got n=%0d want addr 400 at cycle 1", rd_a.size());
        else pass_cnt++;
        total_cnt++;
        if (wr_n != 1 || wr_a[0] !== 32'h404 || wr_c[0] != 3)
            $display("FAIL single_write_addr: got n=%0d want one write to 404 at cycle 3", wr_n);
        else pass_cnt++;
        total_cnt++;
        if (wr_d.size() < 1 || wr_d[0] !== 32'hB791F3DD)
            $display("FAIL single_wdata: got %h want b791f3dd", (wr_d.size() > 0) ? wr_d[0] : 32'hx);
        else pass_cnt++;
        total_cnt++;
        if (done_cyc != 4 || done_cnt != 1 || wd_at_done !== 32'd1)
            $display("FAIL single_done: got cyc=%0d cnt=%0d wdn=%h want 4 1 1", done_cyc, done_cnt, wd_at_done);
        else pass_cnt++;
        total_cnt++;
        if (busy_after !== 1'b0 || words_done !== 32'd1)
            $display("FAIL single_after: got busy=%b wdn=%h want 0 1", busy_after, words_done);
        else pass_cnt++;
    endtask

    task automatic test_zero();
        run_job(32'd0, 32'h1234, 10, -1, 0, 0);
        total_cnt++;
        if (wr_n != 0 || rd_n != 0) $display("FAIL zero_no_access: got wr=%0d rd=%0d want 0 0", wr_n, rd_n);
        else pass_cnt++;
        total_cnt++;
        if (done_cyc != 1 || busy_cnt != 1 || wd_at_done !== 32'd0)
            $display("FAIL zero_done: got cyc=%0d busy=%0d wdn=%h want 1 1 0", done_cyc, busy_cnt, wd_at_done);
        else pass_cnt++;
    endtask

    task automatic test_multi();
        logic [31:0] exp_a [0:3];
        logic [31:0] exp_d [0:3];
        exp_a = '{32'h404, 32'h408, 32'h40C, 32'h410};
        exp_d = '{32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'hFFFFFFFC};
        for (int j = 0; j < 4; j++) src_mem[j] = j;
        run_job(32'd4, 32'hFFFFFFFF, 30, -1, 0, 0);
        total_cnt++;
        if (wr_n != 4) $display("FAIL multi_count: got %0d want 4", wr_n); else pass_cnt++;
        for (int j = 0; j < 4 && j < wr_a.size(); j++) begin
            total_cnt++;
            if (wr_a[j] !== exp_a[j] || wr_d[j] !== exp_d[j] || wr_c[j] != 3 * j + 3)
                $display("FAIL multi_write%0d: got a=%h d=%h c=%0d want a=%h d=%h c=%0d",
                         j, wr_a[j], wr_d[j], wr_c[j], exp_a[j], exp_d[j], 3 * j + 3);
            else pass_cnt++;
        end
        total_cnt++;
        if (done_cyc != 13 || wd_at_done !== 32'd4)
            $display("FAIL multi_done: got cyc=%0d wdn=%h want 13 4", done_cyc, wd_at_done);
        else pass_cnt++;
    endtask

    task automatic test_clamp();
        run_job(32'hFFFFFFFF, 32'h0, 3 * 32'h4F00 + 10, -1, 0, 0);
        total_cnt++;
        if (last_wa !== 32'h14000 || wr_n != 32'h4F00)
            $display("FAIL clamp_last_write: got a=%h n=%0d want 14000 %0d", last_wa, wr_n, 32'h4F00);
        else pass_cnt++;
        total_cnt++;
        if (max_ra !== 32'h13FFC) $display("FAIL clamp_max_read: got %h want 13ffc", max_ra); else pass_cnt++;
        total_cnt++;
        if (wd_at_done !== 32'h4F00 || done_cyc != 3 * 32'h4F00 + 1)
            $display("FAIL clamp_done: got wdn=%h cyc=%0d want 4f00 %0d", wd_at_done, done_cyc, 3 * 32'h4F00 + 1);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back_start();
        src_mem[0] = 32'h11111111;
        src_mem[1] = 32'h22222222;
        run_job(32'd2, 32'h0F0F0F0F, 30, 2, 32'd7, 32'hFFFFFFFF);
        total_cnt++;
        if (wr_n != 2 || wr_d[0] !== 32'h1E1E1E1E || wr_d[1] !== 32'h2D2D2D2D)
            $display("FAIL busy_start_data: got n=%0d want 2 writes 1e1e1e1e 2d2d2d2d", wr_n);
        else pass_cnt++;
        total_cnt++;
        if (done_cnt != 1 || done_cyc != 7 || wd_at_done !== 32'd2)
            $display("FAIL busy_start_done: got cnt=%0d cyc=%0d wdn=%h want 1 7 2", done_cnt, done_cyc, wd_at_done);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_job();
        int stray;
        @(negedge clk);
        start = 1'b1; word_count = 32'd5; key = 32'h5;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);   // now in cycle 6: write of word 2
        total_cnt++;
        if (mem_we !== 1'b1 || mem_address !== 32'h408)
            $display("FAIL midjob_write2: got we=%b a=%h want 1 408", mem_we, mem_address);
        else pass_cnt++;
        rst = 1'b1;
        #1;
        total_cnt++;
        if ({mem_address, mem_we, mem_wdata, busy, done, words_done} !== '0)
            $display("FAIL midjob_async_clear: got a=%h we=%b busy=%b wdn=%h want all 0",
                     mem_address, mem_we, busy, words_done);
        else pass_cnt++;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        stray = 0;
        repeat (20) begin
            @(negedge clk);
            if (mem_we || busy) stray++;
        end
        total_cnt++;
        if (stray != 0) $display("FAIL midjob_no_write_after: got %0d active cycles want 0", stray);
        else pass_cnt++;
        src_mem[0] = 32'hCAFEF00D;
        run_job(32'd1, 32'h0000FFFF, 20, -1, 0, 0);
        total_cnt++;
        if (wr_n != 1 || wr_d[0] !== 32'hCAFE0FF2 || done_cyc != 4 || wd_at_done !== 32'd1)
            $display("FAIL midjob_restart: got n=%0d cyc=%0d wdn=%h want 1 write cafe0ff2 done 4 wdn 1",
                     wr_n, done_cyc, wd_at_done);
        else pass_cnt++;
    endtask

    initial begin
        for (int j = 0; j < 8; j++) src_mem[j] = 32'h0;
        test_reset();
        test_single();
        test_zero();
        test_multi();
        test_clamp();
        test_back_to_back_start();
        test_reset_mid_job();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
